sdram_client_responder: RTL and testbench

- Behavioural responder for the byte-wide SDRAM controller client interface: accepts rd/wr/refresh pulses and answers with busy, data_ready and dout, with controller-like latencies.
- Backed by a small on-chip byte RAM. Lets traffic generators and test FSMs run in simulation or on-board without the physical SDRAM.
- Also polices the client: flags commands issued while busy, multiple simultaneous commands, and refresh starvation.

---
 rtl/sdram_client_pkg.sv | 42 ++++
 rtl/byte_ram.sv | 31 +++
 rtl/sdram_client_responder.sv | 157 +++++++++++++++
 tb/tb_sdram_client_responder.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_client_pkg.sv
// Shared types and constants for the byte-wide SDRAM client interface.
// Used by the behavioural responder and matched by the real controller's documentation.
package sdram_client_pkg;

    localparam int unsigned ADDR_W = 23;
    localparam int unsigned DATA_W = 8;

    localparam int unsigned DEF_RD_LAT  = 4;
    localparam int unsigned DEF_WR_LAT  = 3;
    localparam int unsigned DEF_REF_LAT = 5;

    typedef enum logic [1:0] {
        StIdle,
        StRd,
        StWr,
        StRef
    } state_e;

    typedef enum logic [1:0] {
        CmdNone,
        CmdRd,
        CmdWr,
        CmdRef
    } cmd_e;

    // Refresh beats write beats read when the client pulses several at once.
    function automatic cmd_e pick_cmd(input logic rd, input logic wr, input logic refresh);
        if (refresh) begin
            return CmdRef;
        end else if (wr) begin
            return CmdWr;
        end else if (rd) begin
            return CmdRd;
        end
        return CmdNone;
    endfunction

    function automatic logic multi_cmd(input logic rd, input logic wr, input logic refresh);
        return (rd & wr) | (rd & refresh) | (wr & refresh);
    endfunction

endpackage

// File: rtl/byte_ram.sv
// Single-port byte RAM: synchronous write, synchronous read, no reset.
// Read data holds until the next enabled read.
module byte_ram
    import sdram_client_pkg::*;
#(
    parameter int unsigned AW = 12
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [2**AW];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem_q[addr] <= wdata;
            end else begin
                rdata_q <= mem_q[addr];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sdram_client_responder.sv
// Behavioural stand-in for the SDRAM controller client port, backed by a small byte RAM.
// Reproduces controller latencies and flags handshake abuse and refresh starvation.
module sdram_client_responder
    import sdram_client_pkg::*;
#(
    parameter int unsigned FREQ        = 27_000_000,
    parameter int unsigned AW          = 12,
    parameter int unsigned RD_LAT      = DEF_RD_LAT,
    parameter int unsigned WR_LAT      = DEF_WR_LAT,
    parameter int unsigned REF_LAT     = DEF_REF_LAT,
    parameter int unsigned MAX_REF_GAP = 1024
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [ADDR_W-1:0] addr,
    input  logic              rd,
    input  logic              wr,
    input  logic              refresh,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              data_ready,
    output logic              busy,
    output logic              protocol_err,
    output logic              refresh_late
);

    if (RD_LAT < 2 || RD_LAT > 15) begin : g_bad_rd_lat
        $error("RD_LAT must be in 2..15");
    end
    if (WR_LAT < 1 || WR_LAT > 15) begin : g_bad_wr_lat
        $error("WR_LAT must be in 1..15");
    end
    if (REF_LAT < 1 || REF_LAT > 15) begin : g_bad_ref_lat
        $error("REF_LAT must be in 1..15");
    end
    if (FREQ == 0 || MAX_REF_GAP == 0) begin : g_bad_timing
        $error("FREQ and MAX_REF_GAP must be non-zero");
    end

    localparam logic [3:0] RD_LAT_C  = 4'(RD_LAT);
    localparam logic [3:0] WR_LAT_C  = 4'(WR_LAT);
    localparam logic [3:0] REF_LAT_C = 4'(REF_LAT);

    localparam int unsigned      GAP_W   = $clog2(MAX_REF_GAP + 1);
    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(MAX_REF_GAP);

    state_e            state_q, state_d;
    logic [3:0]        lat_q, lat_d;
    logic              data_ready_q, data_ready_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              perr_q, perr_d;
    logic              late_q, late_d;
    logic [GAP_W-1:0]  gap_q, gap_d;

    cmd_e              cmd_win;
    logic              any_cmd;
    logic              idle;
    logic              ref_accept;
    logic              ram_en;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata;

    // Upper address bits alias onto the small backing RAM.
    logic unused_addr;
    assign unused_addr = ^addr[ADDR_W-1:AW];

    assign cmd_win    = pick_cmd(rd, wr, refresh);
    assign any_cmd    = rd | wr | refresh;
    assign idle       = (state_q == StIdle);
    assign ref_accept = idle && (cmd_win == CmdRef);
    assign ram_en     = idle && (cmd_win == CmdRd || cmd_win == CmdWr);
    assign ram_we     = (cmd_win == CmdWr);

    byte_ram #(
        .AW (AW)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (addr[AW-1:0]),
        .wdata (din),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        unique case (state_q)
            StIdle: begin
                unique case (cmd_win)
                    CmdRef: begin
                        state_d = StRef;
                        lat_d   = REF_LAT_C;
                    end
                    CmdWr: begin
                        state_d = StWr;
                        lat_d   = WR_LAT_C;
                    end
                    CmdRd: begin
                        state_d = StRd;
                        lat_d   = RD_LAT_C;
                    end
                    default: ;
                endcase
            end
            default: begin
                // lat_q counts the busy cycles still to go, including the current one.
                if (lat_q == 4'd1) begin
                    state_d = StIdle;
                end else begin
                    lat_d = lat_q - 4'd1;
                end
            end
        endcase
    end

    always_comb begin
        data_ready_d = (state_q == StRd) && (lat_q == 4'd2);
        dout_d       = data_ready_d ? ram_rdata : dout_q;
        perr_d       = perr_q | (any_cmd & (~idle | multi_cmd(rd, wr, refresh)));

        gap_d = gap_q;
        if (ref_accept) begin
            gap_d = '0;
        end else if (gap_q != GAP_MAX) begin
            gap_d = gap_q + GAP_W'(1);
        end
        late_d = late_q | (!ref_accept && gap_d == GAP_MAX);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= StIdle;
            lat_q        <= '0;
            data_ready_q <= 1'b0;
            dout_q       <= '0;
            perr_q       <= 1'b0;
            late_q       <= 1'b0;
            gap_q        <= '0;
        end else begin
            state_q      <= state_d;
            lat_q        <= lat_d;
            data_ready_q <= data_ready_d;
            dout_q       <= dout_d;
            perr_q       <= perr_d;
            late_q       <= late_d;
            gap_q        <= gap_d;
        end
    end

    assign dout         = dout_q;
    assign data_ready   = data_ready_q;
    assign busy         = !idle;
    assign protocol_err = perr_q;
    assign refresh_late = late_q;

endmodule

// File: tb/tb_sdram_client_responder.sv
// Randomised scoreboard bench for sdram_client_responder against a cycle-count reference model.
module tb_sdram_client_responder;

    localparam int AW          = 12;
    localparam int RD_LAT      = 4;
    localparam int WR_LAT      = 3;
    localparam int REF_LAT     = 5;
    localparam int MAX_REF_GAP = 1024;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [22:0] addr = '0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic        refresh = 1'b0;
    logic [7:0]  din = '0;
    logic [7:0]  dout;
    logic        data_ready;
    logic        busy;
    logic        protocol_err;
    logic        refresh_late;

    always #5 clk = ~clk;

    sdram_client_responder #(
        .FREQ        (27_000_000),
        .AW          (AW),
        .RD_LAT      (RD_LAT),
        .WR_LAT      (WR_LAT),
        .REF_LAT     (REF_LAT),
        .MAX_REF_GAP (MAX_REF_GAP)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .addr         (addr),
        .rd           (rd),
        .wr           (wr),
        .refresh      (refresh),
        .din          (din),
        .dout         (dout),
        .data_ready   (data_ready),
        .busy         (busy),
        .protocol_err (protocol_err),
        .refresh_late (refresh_late)
    );

    typedef struct {
        logic [7:0] data;
        int         due;
    } rd_exp_t;

    // Reference model: cycle index, first free cycle, last accepted refresh cycle.
    rd_exp_t    exp_q[$];
    logic [7:0] mem_m [1 << AW];
    int         cyc = 0;
    int         free_at = 0;
    int         last_ref = -1;
    bit         perr_m = 1'b0;
    bit         late_m = 1'b0;
    logic [7:0] dout_m = '0;

    int checks = 0;
    int passed = 0;

    function automatic void check(input string name, input int unsigned act,
                                  input int unsigned exp);
        checks++;
        if (act == exp) begin
            passed++;
        end else begin
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endfunction

    initial begin
        int n;
        int idx;
        rd_exp_t e;
        forever begin
            @(posedge clk or negedge resetn);
            if (!resetn) begin
                cyc      = 0;
                free_at  = 0;
                last_ref = -1;
                perr_m   = 1'b0;
                late_m   = 1'b0;
                dout_m   = '0;
                exp_q.delete();
            end else begin
                n   = int'(rd) + int'(wr) + int'(refresh);
                idx = int'(addr) % (1 << AW);
                if (n > 0) begin
                    if (cyc < free_at) begin
                        perr_m = 1'b1;
                    end else begin
                        if (n > 1) perr_m = 1'b1;
                        if (refresh) begin
                            free_at  = cyc + REF_LAT + 1;
                            last_ref = cyc;
                        end else if (wr) begin
                            mem_m[idx] = din;
                            free_at    = cyc + WR_LAT + 1;
                        end else begin
                            e.data  = mem_m[idx];
                            e.due   = cyc + RD_LAT;
                            exp_q.push_back(e);
                            free_at = cyc + RD_LAT + 1;
                        end
                    end
                end
                cyc++;
                if (cyc - last_ref - 1 >= MAX_REF_GAP) late_m = 1'b1;
            end
        end
    end

    // Monitor: compares every output once per cycle, popping expected reads when due.
    initial begin
        bit exp_dr;
        forever begin
            @(negedge clk);
            #1;
            exp_dr = (exp_q.size() > 0) && (exp_q[0].due == cyc);
            check("data_ready", data_ready, exp_dr);
            if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                if (exp_dr) dout_m = exp_q[0].data;
                void'(exp_q.pop_front());
            end
            check("dout", dout, dout_m);
            check("busy", busy, (cyc < free_at) ? 1 : 0);
            check("protocol_err", protocol_err, perr_m);
            check("refresh_late", refresh_late, late_m);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cmd(input logic r, input logic w, input logic f, input logic [22:0] a,
                       input logic [7:0] d);
        rd = r;
        wr = w;
        refresh = f;
        addr = a;
        din = d;
        @(negedge clk);
        rd = 1'b0;
        wr = 1'b0;
        refresh = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 64 && cyc < free_at; i++) @(negedge clk);
        if (cyc < free_at) check("wait_idle_timeout", busy, 0);
    endtask

    initial begin
        logic [22:0] a;
        int sel;
        idle(3);
        resetn = 1'b1;
        idle(2);

        for (int i = 0; i < 64; i++) begin
            cmd(1'b0, 1'b1, 1'b0, 23'(i), 8'($urandom));
            idle(WR_LAT);
        end

        // Write/write/read chain with no protocol errors.
        cmd(1'b0, 1'b1, 1'b0, 23'd0, 8'h3E);
        idle(3);
        cmd(1'b0, 1'b1, 1'b0, 23'd1, 8'hED);
        idle(3);
        cmd(1'b1, 1'b0, 1'b0, 23'd1, 8'h00);
        idle(3);
        check("rd_chain_dout", dout, 8'hED);
        idle(2);
        check("rd_chain_no_err", protocol_err, 0);

        cmd(1'b0, 1'b0, 1'b1, 23'd0, 8'h00);
        idle(REF_LAT);

        // Read while busy is ignored, read on the first free cycle is accepted.
        cmd(1'b0, 1'b1, 1'b0, 23'd5, 8'h6C);
        idle(2);
        cmd(1'b1, 1'b0, 1'b0, 23'd5, 8'h00);
        cmd(1'b1, 1'b0, 1'b0, 23'd5, 8'h00);
        idle(3);
        check("rd_after_busy_dout", dout, 8'h6C);
        check("busy_err_flag", protocol_err, 1);
        idle(2);

        // rd+wr together: only the write runs.
        cmd(1'b1, 1'b1, 1'b0, 23'd7, 8'h55);
        idle(3);
        cmd(1'b1, 1'b0, 1'b0, 23'd7, 8'h00);
        idle(5);

        // Aliasing above AW.
        cmd(1'b0, 1'b1, 1'b0, 23'h001000, 8'hA5);
        idle(3);
        cmd(1'b1, 1'b0, 1'b0, 23'h000000, 8'h00);
        idle(5);
        check("alias_dout", dout, 8'hA5);

        // Random traffic with a clean refresh at the start of every block.
        for (int b = 0; b < 4; b++) begin
            wait_idle();
            cmd(1'b0, 1'b0, 1'b1, 23'd0, 8'h00);
            for (int k = 0; k < 100; k++) begin
                a   = {11'($urandom), 6'b0, 6'($urandom)};
                sel = int'($urandom_range(0, 9));
                case (sel)
                    0, 1, 2, 3: cmd(1'b1, 1'b0, 1'b0, a, 8'($urandom));
                    4, 5, 6, 7: cmd(1'b0, 1'b1, 1'b0, a, 8'($urandom));
                    8:          cmd(1'b1, 1'b1, 1'b0, a, 8'($urandom));
                    default:    cmd(1'b1, 1'b0, 1'b1, a, 8'($urandom));
                endcase
                idle(int'($urandom_range(0, 6)));
            end
        end

        // Refresh every 1000 cycles keeps the starvation flag clear.
        wait_idle();
        for (int i = 0; i < 5; i++) begin
            cmd(1'b0, 1'b0, 1'b1, 23'd0, 8'h00);
            idle(999);
        end
        check("late_clear_with_refresh", refresh_late, 0);
        idle(1100);
        check("late_set_after_gap", refresh_late, 1);
        cmd(1'b0, 1'b0, 1'b1, 23'd0, 8'h00);
        idle(20);
        cmd(1'b0, 1'b0, 1'b1, 23'd0, 8'h00);
        idle(20);
        check("late_sticky", refresh_late, 1);

        // Reset in the middle of a read aborts it; a committed write survives.
        wait_idle();
        cmd(1'b1, 1'b0, 1'b0, 23'd9, 8'h00);
        idle(1);
        resetn = 1'b0;
        idle(2);
        check("reset_busy", busy, 0);
        check("reset_dout", dout, 0);
        resetn = 1'b1;
        idle(8);
        cmd(1'b0, 1'b1, 1'b0, 23'd10, 8'hC3);
        resetn = 1'b0;
        idle(2);
        resetn = 1'b1;
        idle(2);
        cmd(1'b1, 1'b0, 1'b0, 23'd9, 8'h00);
        idle(5);
        cmd(1'b1, 1'b0, 1'b0, 23'd10, 8'h00);
        idle(5);
        check("write_survives_reset", dout, 8'hC3);
        idle(5);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passed, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
